// File: rtl/pcie_cfg_sequencer.sv
// pcie_cfg_sequencer: boot-time configuration sequencer for the PCIE_CORE
// LMMI register port. After start it walks an external (offset, data, mask)
// table and applies each entry as a masked read-modify-write.
// Optional feature macro: PCIE_CFG_VERIFY_EN adds a readback check after
// every write; the failing entry is reported through error/err_index.
module pcie_cfg_sequencer #(
  parameter int OFFSET_W  = 15,
  parameter int DATA_W    = 32,
  parameter int N_ENTRIES = 16,
  parameter int TIMEOUT   = 255,
  localparam int IDX_W    = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [IDX_W-1:0]    err_index,
  output logic [IDX_W-1:0]    tbl_addr,
  input  logic [OFFSET_W-1:0] tbl_offset,
  input  logic [DATA_W-1:0]   tbl_wdata,
  input  logic [DATA_W-1:0]   tbl_mask,
  output logic                lmmi_request,
  output logic                lmmi_wr_rdn,
  output logic [OFFSET_W-1:0] lmmi_offset,
  output logic [DATA_W-1:0]   lmmi_wdata,
  input  logic                lmmi_ready,
  input  logic [DATA_W-1:0]   lmmi_rdata,
  input  logic                lmmi_rdata_valid
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);
  localparam logic [15:0]      TMO_MAX  = 16'(TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_NEXT,
    S_DONE,
`ifdef PCIE_CFG_VERIFY_EN
    S_VFY_REQ,
    S_VFY_WAIT,
`endif
    S_ERR
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_tmo;
  logic [IDX_W-1:0]      r_index;
  logic [IDX_W-1:0]      r_err_index;
  logic                  r_done;
  logic                  r_error;
  logic [OFFSET_W-1:0]   r_offset;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_mask;
  logic [DATA_W-1:0]     r_merged;
  logic                  w_tmo;
  logic                  w_req;
  logic                  w_wr;
  logic [DATA_W-1:0]     w_merged;
`ifdef PCIE_CFG_VERIFY_EN
  logic                  w_vfy_bad;
`endif

  // Timeout is reached once the wait counter hits TIMEOUT; at that point the
  // request is withdrawn and any late handshake is ignored.
  assign w_tmo    = (r_tmo == TMO_MAX);
  assign w_merged = (lmmi_rdata & ~r_mask) | (r_wdata & r_mask);
`ifdef PCIE_CFG_VERIFY_EN
  assign w_vfy_bad = |((lmmi_rdata ^ r_merged) & r_mask);
`endif

  assign busy         = (r_state != S_IDLE);
  assign done         = r_done;
  assign error        = r_error;
  assign err_index    = r_err_index;
  assign tbl_addr     = r_index;
  assign lmmi_request = w_req;
  assign lmmi_wr_rdn  = w_wr;
  assign lmmi_offset  = r_offset;
  assign lmmi_wdata   = r_merged;

  // State register; reset aborts any transfer in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and LMMI request decode.
  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    w_wr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_next = S_DECODE;
      end
      S_DECODE: begin
        if (tbl_mask == '0) begin
          w_next = S_NEXT;
        end else if (&tbl_mask) begin
          w_next = S_WR_REQ;
        end else begin
          w_next = S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (w_tmo) begin
          w_next = S_ERR;
        end else begin
          w_req = 1'b1;
          if (lmmi_ready) begin
            w_next = S_RD_WAIT;
          end
        end
      end
      S_RD_WAIT: begin
        if (w_tmo) begin
          w_next = S_ERR;
        end else if (lmmi_rdata_valid) begin
          w_next = S_WR_REQ;
        end
      end
      S_WR_REQ: begin
        if (w_tmo) begin
          w_next = S_ERR;
        end else begin
          w_req = 1'b1;
          w_wr  = 1'b1;
          if (lmmi_ready) begin
`ifdef PCIE_CFG_VERIFY_EN
            w_next = S_VFY_REQ;
`else
            w_next = S_NEXT;
`endif
          end
        end
      end
`ifdef PCIE_CFG_VERIFY_EN
      S_VFY_REQ: begin
        if (w_tmo) begin
          w_next = S_ERR;
        end else begin
          w_req = 1'b1;
          if (lmmi_ready) begin
            w_next = S_VFY_WAIT;
          end
        end
      end
      S_VFY_WAIT: begin
        if (w_tmo) begin
          w_next = S_ERR;
        end else if (lmmi_rdata_valid) begin
          w_next = w_vfy_bad ? S_ERR : S_NEXT;
        end
      end
`endif
      S_NEXT: begin
        w_next = (r_index == LAST_IDX) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      S_ERR: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Per-state wait counter: restarts on every state change, saturates at TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo <= '0;
    end else if (w_next != r_state) begin
      r_tmo <= '0;
    end else if (r_tmo != TMO_MAX) begin
      r_tmo <= r_tmo + 16'd1;
    end
  end

  // Table index and sticky status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_index     <= '0;
      r_err_index <= '0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_index     <= '0;
        r_err_index <= '0;
        r_done      <= 1'b0;
        r_error     <= 1'b0;
      end
      if (r_state == S_NEXT && r_index != LAST_IDX) begin
        r_index <= r_index + 1'b1;
      end
      if (w_next == S_DONE) begin
        r_done <= 1'b1;
      end
      if (w_next == S_ERR) begin
        r_error     <= 1'b1;
        r_err_index <= r_index;
      end
    end
  end

  // Entry latch and merged write data; these also hold the request outputs
  // stable while the slave stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_offset <= '0;
      r_wdata  <= '0;
      r_mask   <= '0;
      r_merged <= '0;
    end else begin
      if (r_state == S_DECODE) begin
        r_offset <= tbl_offset;
        r_wdata  <= tbl_wdata;
        r_mask   <= tbl_mask;
        if (&tbl_mask) begin
          r_merged <= tbl_wdata;
        end
      end
      if (r_state == S_RD_WAIT && !w_tmo && lmmi_rdata_valid) begin
        r_merged <= w_merged;
      end
    end
  end

endmodule

// File: tb/tb_pcie_cfg_sequencer.sv
// tb_pcie_cfg_sequencer: scoreboard bench for pcie_cfg_sequencer with a
// behavioural LMMI slave and a table-level reference model.
// Honours PCIE_CFG_VERIFY_EN when the bench is built with it defined.
module tb_pcie_cfg_sequencer;

  localparam int NE   = 4;
  localparam int TOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [1:0]  err_index, tbl_addr;
  logic [14:0] tbl_offset;
  logic [31:0] tbl_wdata, tbl_mask;
  logic        lmmi_request, lmmi_wr_rdn;
  logic [14:0] lmmi_offset;
  logic [31:0] lmmi_wdata;
  logic        lmmi_ready = 1'b0;
  logic [31:0] lmmi_rdata = '0;
  logic        lmmi_rdata_valid = 1'b0;

  typedef struct {
    bit          wr;
    int          off;
    logic [31:0] data;
  } txn_t;

  txn_t        expQ[$];
  int          testsRun = 0;
  int          testsFailed = 0;

  int          tblOff[NE];
  logic [31:0] tblDat[NE];
  logic [31:0] tblMsk[NE];

  // slave knobs and state
  bit          tieReady = 0;
  int          wrDelayFixed = -1;
  int          rdDelayFixed = -1;
  int          vDelayFixed = -1;
  bit          dropEn = 0;
  int          dropOff = 0;
  bit          corruptEn = 0;
  int          corruptOff = 0;
  bit          spurious = 1;
  bit          dropped = 0;
  bit          inReq = 0;
  int          reqDelay = 0;
  bit          pendRead = 0;
  int          pendOff = 0;
  int          pendDelay = 0;
  int          acceptedWr = 0;
  int          acceptedRd = 0;
  logic [31:0] slvMem [int];
  bit          slvWritten [int];

  // model state
  logic [31:0] refMem [int];
  bit          refWritten [int];
  bit          expErr;
  int          expIdx;

  pcie_cfg_sequencer #(
    .OFFSET_W (15),
    .DATA_W   (32),
    .N_ENTRIES(NE),
    .TIMEOUT  (TOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .err_index       (err_index),
    .tbl_addr        (tbl_addr),
    .tbl_offset      (tbl_offset),
    .tbl_wdata       (tbl_wdata),
    .tbl_mask        (tbl_mask),
    .lmmi_request    (lmmi_request),
    .lmmi_wr_rdn     (lmmi_wr_rdn),
    .lmmi_offset     (lmmi_offset),
    .lmmi_wdata      (lmmi_wdata),
    .lmmi_ready      (lmmi_ready),
    .lmmi_rdata      (lmmi_rdata),
    .lmmi_rdata_valid(lmmi_rdata_valid)
  );

  always #5 clk = ~clk;

  // Synchronous table ROM: contents appear one cycle after the address.
  always @(posedge clk) begin
    tbl_offset <= 15'(tblOff[tbl_addr]);
    tbl_wdata  <= tblDat[tbl_addr];
    tbl_mask   <= tblMsk[tbl_addr];
  end

  function automatic logic [31:0] initVal(int off);
    if (off == 32'h40) return 32'h12345600;
    return 32'hC0DE0000 ^ (32'(off) * 32'h9E3779B1);
  endfunction

  function automatic logic [31:0] slvRead(int off);
    logic [31:0] v;
    v = slvMem.exists(off) ? slvMem[off] : initVal(off);
    if (corruptEn && off == corruptOff && slvWritten.exists(off)) v = v ^ 32'h1;
    return v;
  endfunction

  function automatic logic [31:0] refRead(int off);
    logic [31:0] v;
    v = refMem.exists(off) ? refMem[off] : initVal(off);
    if (corruptEn && off == corruptOff && refWritten.exists(off)) v = v ^ 32'h1;
    return v;
  endfunction

  // Behavioural LMMI slave: decides ready/valid on the falling edge so the
  // DUT samples stable values on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      lmmi_ready       = 1'b0;
      lmmi_rdata_valid = 1'b0;
      inReq            = 0;
      pendRead         = 0;
    end else begin
      lmmi_rdata_valid = 1'b0;
      if (pendRead) begin
        if (pendDelay == 0) begin
          pendRead = 0;
          if (dropEn && pendOff == dropOff) begin
            dropped = 1;
          end else begin
            lmmi_rdata_valid = 1'b1;
            lmmi_rdata       = slvRead(pendOff);
          end
        end else begin
          pendDelay--;
        end
      end else if (spurious && !dropped && $urandom_range(7) == 0) begin
        lmmi_rdata_valid = 1'b1;
        lmmi_rdata       = $urandom;
      end
      if (lmmi_request) begin
        if (!inReq) begin
          inReq = 1;
          if (tieReady) reqDelay = 0;
          else if (lmmi_wr_rdn && wrDelayFixed >= 0) reqDelay = wrDelayFixed;
          else if (!lmmi_wr_rdn && rdDelayFixed >= 0) reqDelay = rdDelayFixed;
          else reqDelay = $urandom_range(3);
        end
        if (reqDelay == 0) begin
          lmmi_ready = 1'b1;
          inReq      = 0;
          if (lmmi_wr_rdn) begin
            slvMem[int'(lmmi_offset)]     = lmmi_wdata;
            slvWritten[int'(lmmi_offset)] = 1;
            acceptedWr++;
          end else begin
            pendRead  = 1;
            pendOff   = int'(lmmi_offset);
            pendDelay = (vDelayFixed >= 0) ? vDelayFixed : $urandom_range(3);
            acceptedRd++;
          end
        end else begin
          lmmi_ready = 1'b0;
          reqDelay--;
        end
      end else begin
        lmmi_ready = tieReady;
        inReq      = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted LMMI request and checks
  // that a stalled request stays unchanged.
  bit          prevReq = 0;
  bit          prevRdy = 0;
  bit          prevWr = 0;
  logic [14:0] prevOff = '0;
  logic [31:0] prevWd = '0;
  always @(negedge clk) begin
    txn_t e;
    #1;
    if (rst) begin
      prevReq = 0;
    end else begin
      if (prevReq && !prevRdy) begin
        testsRun++;
        if (!(lmmi_request && lmmi_wr_rdn == prevWr && lmmi_offset == prevOff && lmmi_wdata == prevWd)) begin
          testsFailed++;
          $display("[TB] FAIL stall_stable: got req=%0b wr=%0b off=%h wd=%h expected req=1 wr=%0b off=%h wd=%h",
                   lmmi_request, lmmi_wr_rdn, lmmi_offset, lmmi_wdata, prevWr, prevOff, prevWd);
        end
      end
      if (lmmi_request && lmmi_ready) begin
        testsRun++;
        if (expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL unexpected_txn: got wr=%0b off=%h wd=%h expected no request",
                   lmmi_wr_rdn, lmmi_offset, lmmi_wdata);
        end else begin
          e = expQ.pop_front();
          if (lmmi_wr_rdn != e.wr || int'(lmmi_offset) != e.off || (e.wr && lmmi_wdata != e.data)) begin
            testsFailed++;
            $display("[TB] FAIL txn: got wr=%0b off=%h wd=%h expected wr=%0b off=%h wd=%h",
                     lmmi_wr_rdn, lmmi_offset, lmmi_wdata, e.wr, e.off[14:0], e.data);
          end
        end
      end
      prevReq = lmmi_request;
      prevRdy = lmmi_ready;
      prevWr  = lmmi_wr_rdn;
      prevOff = lmmi_offset;
      prevWd  = lmmi_wdata;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: derives the LMMI transaction list and final status
  // straight from the table semantics.
  task automatic modelSequence();
    logic [31:0] m, d, cur, merged, rb;
    int o;
    expQ.delete();
    refMem.delete();
    refWritten.delete();
    expErr = 0;
    expIdx = 0;
    for (int i = 0; i < NE; i++) begin
      o = tblOff[i];
      m = tblMsk[i];
      d = tblDat[i];
      if (m == 32'h0) continue;
      if (m == 32'hFFFFFFFF) begin
        merged = d;
      end else begin
        expQ.push_back('{0, o, 32'h0});
        if (dropEn && o == dropOff) begin
          expErr = 1; expIdx = i; break;
        end
        cur    = refRead(o);
        merged = (cur & ~m) | (d & m);
      end
      expQ.push_back('{1, o, merged});
      refMem[o]     = merged;
      refWritten[o] = 1;
`ifdef PCIE_CFG_VERIFY_EN
      expQ.push_back('{0, o, 32'h0});
      if (dropEn && o == dropOff) begin
        expErr = 1; expIdx = i; break;
      end
      rb = refRead(o);
      if (((rb ^ merged) & m) != 32'h0) begin
        expErr = 1; expIdx = i; break;
      end
`else
      rb = 32'h0;
`endif
    end
  endtask

  // Runs one full sequence and checks the end status against the model.
  task automatic applyStimulus(input bit extraStart, output int doneCycle);
    int cyc;
    modelSequence();
    slvMem.delete();
    slvWritten.delete();
    acceptedWr = 0;
    acceptedRd = 0;
    dropped    = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy_rise", 32'(busy), 32'd1);
    checkOutput("tbl_addr_first", 32'(tbl_addr), 32'd0);
    checkOutput("flags_cleared", {30'd0, done, error}, 32'd0);
    cyc = 1;
    doneCycle = -1;
    while (busy && cyc < 400) begin
      start = (extraStart && cyc == 4);
      @(negedge clk);
      cyc++;
      if (done && doneCycle < 0) doneCycle = cyc;
    end
    start = 1'b0;
    checkOutput("seq_finished", 32'(busy), 32'd0);
    checkOutput("done", 32'(done), 32'(!expErr));
    checkOutput("error", 32'(error), 32'(expErr));
    if (expErr) checkOutput("err_index", 32'(err_index), 32'(expIdx));
    checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
  endtask

  task automatic randomTable();
    for (int i = 0; i < NE; i++) begin
      tblOff[i] = (i << 13) | int'($urandom_range(8191));
      tblDat[i] = $urandom;
      case ($urandom_range(3))
        0: tblMsk[i] = 32'h0;
        1: tblMsk[i] = 32'hFFFFFFFF;
        2: tblMsk[i] = 32'h1 << $urandom_range(31);
        default: tblMsk[i] = $urandom | 32'h1;
      endcase
      if (tblMsk[i] == 32'hFFFFFFFF && $urandom_range(1) == 0) tblMsk[i] = 32'hFFFF0F0F;
    end
  endtask

  task automatic clearTable();
    for (int i = 0; i < NE; i++) begin
      tblOff[i] = 32'h100 + i * 4;
      tblDat[i] = 32'h0;
      tblMsk[i] = 32'h0;
    end
  endtask

  initial begin
    int dc;
    int reqHigh;
    bit sawRead;
    clearTable();
    #23;
    checkOutput("reset_outputs",
                {23'd0, busy, done, error, err_index, tbl_addr, lmmi_request, lmmi_wr_rdn}, 32'd0);
    checkOutput("reset_offset_wdata", 32'(lmmi_offset) | lmmi_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // all write-only, ready tied high
    tieReady    = 1;
    vDelayFixed = 0;
    spurious    = 0;
    for (int i = 0; i < NE; i++) begin
      tblOff[i] = 32'h200 + i * 8;
      tblDat[i] = 32'hA0000000 + i;
      tblMsk[i] = 32'hFFFFFFFF;
    end
    applyStimulus(0, dc);
`ifdef PCIE_CFG_VERIFY_EN
    checkOutput("done_cycle", 32'(dc), 32'd25);
    checkOutput("read_count", 32'(acceptedRd), 32'd4);
`else
    checkOutput("done_cycle", 32'(dc), 32'd17);
    checkOutput("read_count", 32'(acceptedRd), 32'd0);
`endif
    checkOutput("write_count", 32'(acceptedWr), 32'd4);
    tieReady    = 0;
    vDelayFixed = -1;
    spurious    = 1;

    // single RMW entry with a known register value
    clearTable();
    tblOff[0] = 32'h40; tblDat[0] = 32'h000000A5; tblMsk[0] = 32'h000000FF;
    applyStimulus(0, dc);
    checkOutput("rmw_result", slvMem[32'h40], 32'h123456A5);
    checkOutput("rmw_writes", 32'(acceptedWr), 32'd1);

    // write stalled by the slave for 3 cycles
    clearTable();
    tblOff[1] = 32'h300; tblDat[1] = 32'hDEADBEEF; tblMsk[1] = 32'hFFFFFFFF;
    wrDelayFixed = 3;
    applyStimulus(0, dc);
    checkOutput("stall_writes", 32'(acceptedWr), 32'd1);
    wrDelayFixed = -1;

    // read data never returned on entry 2
    randomTable();
    tblMsk[2] = 32'h00FF00FF;
    dropEn  = 1;
    dropOff = tblOff[2];
    applyStimulus(0, dc);
    checkOutput("tmo_error", 32'(error), 32'd1);
    checkOutput("tmo_err_index", 32'(err_index), 32'd2);
    reqHigh = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (lmmi_request) reqHigh++;
    end
    checkOutput("tmo_no_requests", 32'(reqHigh), 32'd0);
    dropEn = 0;

    // reset asserted while a read request is pending
    clearTable();
    tblOff[0] = 32'h40; tblDat[0] = 32'h5A; tblMsk[0] = 32'hF0;
    tblOff[3] = 32'h44; tblDat[3] = 32'h77; tblMsk[3] = 32'hFFFFFFFF;
    rdDelayFixed = 5;
    modelSequence();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sawRead = 0;
    for (int i = 0; i < 30 && !sawRead; i++) begin
      @(negedge clk);
      if (lmmi_request && !lmmi_wr_rdn) sawRead = 1;
    end
    checkOutput("rst_reached_rd_req", 32'(sawRead), 32'd1);
    #3 rst = 1'b1;
    #1;
    checkOutput("rst_request_drop", 32'(lmmi_request), 32'd0);
    checkOutput("rst_busy_drop", 32'(busy), 32'd0);
    expQ.delete();
    @(negedge clk);
    #3 rst = 1'b0;
    rdDelayFixed = -1;
    applyStimulus(0, dc);

    // readback corruption on entry 1
    clearTable();
    tblOff[0] = 32'h500; tblDat[0] = 32'h11111111; tblMsk[0] = 32'hFFFFFFFF;
    tblOff[1] = 32'h504; tblDat[1] = 32'h00000001; tblMsk[1] = 32'h00000001;
    corruptEn  = 1;
    corruptOff = 32'h504;
    applyStimulus(0, dc);
`ifdef PCIE_CFG_VERIFY_EN
    checkOutput("vfy_error", 32'(error), 32'd1);
    checkOutput("vfy_err_index", 32'(err_index), 32'd1);
`else
    checkOutput("vfy_done", 32'(done), 32'd1);
`endif
    corruptEn = 0;

    // randomized tables, delays and ignored start pulses
    for (int n = 0; n < 8; n++) begin
      randomTable();
      applyStimulus(n[0], dc);
      checkOutput("flags_exclusive", 32'(done & error), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/pcie_cfg_sequencer.md
# pcie_cfg_sequencer

Boot-time configuration sequencer for the LIFCL PCIE_CORE hard block. After `start`, it walks an external table of (offset, data, mask) entries and applies each one to the core's LMMI register port as a masked read-modify-write. It raises `done` or `error` when the table is finished. It sits between the fabric reset/bring-up logic and the PCIE_CORE LMMI pins, and is the only LMMI master while it is busy.

## Interface
- `OFFSET_W`, 15, LMMI register offset width.
- `DATA_W`, 32, LMMI data width.
- `N_ENTRIES`, 16, number of table entries, ≥1; `IDX_W = $clog2(N_ENTRIES)`, minimum 1.
- `TIMEOUT`, 255, maximum cycles to wait for `lmmi_ready` or `lmmi_rdata_valid`, 1..65535.

Ports:
- `clk` in 1: single clock. LMMI is also clocked by `clk`.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a sequence. Ignored while `busy`.
- `busy` out 1: high from the cycle after an accepted `start` until `done` or `error` rises.
- `done` out 1: sticky success flag, cleared by the next accepted `start`.
- `error` out 1: sticky failure flag, cleared by the next accepted `start`.
- `err_index` out IDX_W: index of the failing entry; valid while `error` is high.
- `tbl_addr` out IDX_W: table read address.
- `tbl_offset` in OFFSET_W, `tbl_wdata` in DATA_W, `tbl_mask` in DATA_W: entry contents, returned one cycle after `tbl_addr` (synchronous ROM).
- `lmmi_request` out 1, `lmmi_wr_rdn` out 1, `lmmi_offset` out OFFSET_W, `lmmi_wdata` out DATA_W: LMMI master outputs.
- `lmmi_ready` in 1, `lmmi_rdata` in DATA_W, `lmmi_rdata_valid` in 1: LMMI slave responses.

## Operation
States:
- IDLE: waits for `start`. On an accepted `start`, clears `done`, `error` and `err_index`, sets index=0, and goes to FETCH.
- FETCH: drives `tbl_addr`=index, waits 1 cycle, then goes to DECODE.
- DECODE: latches the entry.
  - mask==0: goes to NEXT; no bus traffic.
  - mask all-ones: goes to WR_REQ with wdata=tbl_wdata; no read.
  - otherwise: goes to RD_REQ.
- RD_REQ: `lmmi_request`=1, `lmmi_wr_rdn`=0, `lmmi_offset` latched. The request is accepted in the cycle `lmmi_ready`=1, then the FSM goes to RD_WAIT.
- RD_WAIT: request low. On `lmmi_rdata_valid`, computes merged = (rdata & ~mask) | (wdata & mask), then goes to WR_REQ.
- WR_REQ: `lmmi_request`=1, `lmmi_wr_rdn`=1, `lmmi_wdata` set to the merged value. On `lmmi_ready`, goes to VERIFY when the macro is enabled, otherwise to NEXT.
- NEXT: if index==N_ENTRIES-1, goes to DONE. Otherwise index+1 and back to FETCH.
- DONE: sets `done`, returns to IDLE.
- ERR: sets `error`, sets `err_index`=index, returns to IDLE.

Rules:
- Timeout: a 16-bit counter resets on entry to each of RD_REQ, RD_WAIT and WR_REQ. If it reaches TIMEOUT in any of them, the FSM goes to ERR and `lmmi_request` drops in that same cycle.
- `lmmi_rdata_valid` outside RD_WAIT/VERIFY_WAIT is ignored.
- Request outputs are held stable while `lmmi_request`=1 and `lmmi_ready`=0.
- `start` in the same cycle as DONE or ERR is ignored, because `busy` is still high.

## Timing
- Reset values: all outputs 0, FSM in IDLE.
- `rst` mid-sequence aborts immediately (asynchronously). `lmmi_request` falls without waiting for `ready`, and a partial RMW is not resumed.
- `busy` rises 1 cycle after `start`. `tbl_addr` is valid in the first FETCH cycle.
- Best case per RMW entry with `ready` and `valid` returned immediately:
  - FETCH 1 + DECODE 1 + RD_REQ 1 + RD_WAIT ≥1 + WR_REQ 1 + NEXT 1 = 6 cycles.
  - Write-only entry: 4 cycles.
  - Skipped entry (mask==0): 3 cycles.
- `done` and `error` assert one cycle after the last NEXT or the failing state. They are never high together.

## Configuration
- `PCIE_CFG_VERIFY_EN` defined: after each write, VERIFY issues a readback of the same offset (same handshake and timeout as RD_REQ/RD_WAIT). If (rdata ^ merged) & mask ≠ 0, the FSM goes to ERR with `err_index`=index. Adds ≥2 cycles per written entry.
- Not defined: no VERIFY states; WR_REQ goes directly to NEXT.

## Test plan
- N_ENTRIES=4, all masks 0xFFFFFFFF, `ready` tied to 1: exactly 4 writes at the table offsets with the exact table data, and no reads. `done`=1 at cycle 17 after `start`.
- Entry offset 0x0040, data 0x000000A5, mask 0x000000FF; slave returns 0x12345600: one read, then a write of 0x123456A5 to 0x0040.
- Slave holds `lmmi_ready`=0 in WR_REQ for 3 cycles: request, offset and wdata stay stable across all 4 cycles, and exactly one write is accepted.
- Slave never asserts `rdata_valid` on entry 2 with TIMEOUT=8: `error`=1, `err_index`=2, no further requests, `busy`=0.
- Assert `rst` while in RD_REQ, then pulse `start`: `lmmi_request` goes low immediately, and the sequence restarts at index 0.
- With `PCIE_CFG_VERIFY_EN`, the slave corrupts the readback bit 0 of entry 1 (mask 0x1): `error`=1, `err_index`=1. Without the macro, the same stimulus gives `done`=1.
